// File: rtl/ctrl_pkg.sv
// Shared state, opcode and ALUOp definitions for multicycle_controller.
// Defining CTRL_JUMP_EN adds the JUMP state and widens the state code to 4 bits.
package ctrl_pkg;

`ifdef CTRL_JUMP_EN
    localparam int STATE_W = 4;
`else
    localparam int STATE_W = 3;
`endif

    typedef enum logic [STATE_W-1:0] {
        FETCH,
        DECODE,
        EXEC,
        ADDR,
        MEM,
        WB,
        BRANCH,
        ERROR
`ifdef CTRL_JUMP_EN
        , JUMP
`endif
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between multicycle_controller and its datapath/memories.
// state_o width follows the CTRL_JUMP_EN build option via ctrl_pkg.
interface multicycle_controller_if
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7
);
    logic [OPCODE_W-1:0] Opcode;
    logic                imem_ready;
    logic                dmem_ready;
    logic                imem_req;
    logic                ir_write;
    logic                pc_write;
    logic                ALUSrc;
    logic                MemtoReg;
    logic                RegWrite;
    logic                MemRead;
    logic                MemWrite;
    logic                Branch;
    logic [1:0]          ALUOp;
    logic                illegal;
    logic                timeout;
    logic [STATE_W-1:0]  state_o;

    modport master (
        input  Opcode, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, ALUSrc, MemtoReg,
        output RegWrite, MemRead, MemWrite, Branch, ALUOp,
        output illegal, timeout, state_o
    );

    modport slave (
        output Opcode, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, ALUSrc, MemtoReg,
        input  RegWrite, MemRead, MemWrite, Branch, ALUOp,
        input  illegal, timeout, state_o
    );
endinterface

// File: rtl/wait_timer.sv
// Wait-cycle counter for data-memory accesses; expire flags the last
// permitted wait cycle while counting is enabled.
module wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && count != W'(LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = en && (count == W'(LIMIT - 1));
endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V datapath with memory timeouts.
// Build option CTRL_JUMP_EN routes jal/jalr to a JUMP state.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPCODE_W    = 7
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_controller_if.master bus
);
    state_t              state;
    state_t              state_n;
    logic [OPCODE_W-1:0] opc;
    logic                illegal_r;
    logic                timeout_r;
    logic                t_clear;
    logic                t_en;
    logic                t_expire;

    logic is_r, is_i, is_ld, is_st, is_br;
    assign is_r  = (opc == OPCODE_W'(OP_R));
    assign is_i  = (opc == OPCODE_W'(OP_I));
    assign is_ld = (opc == OPCODE_W'(OP_LOAD));
    assign is_st = (opc == OPCODE_W'(OP_STORE));
    assign is_br = (opc == OPCODE_W'(OP_BRANCH));
`ifdef CTRL_JUMP_EN
    logic is_jal, is_jalr;
    assign is_jal  = (opc == OPCODE_W'(OP_JAL));
    assign is_jalr = (opc == OPCODE_W'(OP_JALR));
`endif

    wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (t_clear),
        .en     (t_en),
        .expire (t_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            opc       <= '0;
            illegal_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state <= state_n;
            if (bus.ir_write) opc <= bus.Opcode;
            if (state == DECODE && state_n == ERROR) illegal_r <= 1'b1;
            if (state == MEM && state_n == ERROR) timeout_r <= 1'b1;
        end
    end

    // Strobes are gated by reset so nothing fires while it is held.
    always_comb begin
        state_n      = state;
        t_clear      = 1'b1;
        t_en         = 1'b0;
        bus.imem_req = 1'b0;
        bus.ir_write = 1'b0;
        bus.pc_write = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Branch   = 1'b0;
        bus.ALUOp    = ALUOP_MEM;
        if (!reset) begin
            case (state)
                FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_n      = DECODE;
                    end
                end
                DECODE: begin
                    unique case (1'b1)
                        is_r, is_i:   state_n = EXEC;
                        is_ld, is_st: state_n = ADDR;
                        is_br:        state_n = BRANCH;
`ifdef CTRL_JUMP_EN
                        is_jal, is_jalr: state_n = JUMP;
`endif
                        default:      state_n = ERROR;
                    endcase
                end
                EXEC: begin
                    bus.ALUOp  = ALUOP_RI;
                    bus.ALUSrc = is_i;
                    state_n    = WB;
                end
                ADDR: begin
                    bus.ALUSrc = 1'b1;
                    bus.ALUOp  = ALUOP_MEM;
                    state_n    = MEM;
                end
                MEM: begin
                    t_clear      = 1'b0;
                    bus.MemRead  = is_ld;
                    bus.MemWrite = is_st;
                    if (bus.dmem_ready) begin
                        state_n = is_ld ? WB : FETCH;
                    end else begin
                        t_en = 1'b1;
                        if (t_expire) state_n = ERROR;
                    end
                end
                WB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = is_ld;
                    state_n      = FETCH;
                end
                BRANCH: begin
                    bus.Branch = 1'b1;
                    bus.ALUOp  = ALUOP_BR;
                    state_n    = FETCH;
                end
`ifdef CTRL_JUMP_EN
                JUMP: begin
                    bus.pc_write = 1'b1;
                    bus.RegWrite = 1'b1;
                    bus.ALUSrc   = is_jalr;
                    state_n      = FETCH;
                end
`endif
                ERROR:   state_n = ERROR;
                default: state_n = ERROR;
            endcase
        end
    end

    assign bus.illegal = illegal_r;
    assign bus.timeout = timeout_r;
    assign bus.state_o = state;
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max wait cycles for a memory ready (range 1..255).
REQ-002 SHALL have parameter OPCODE_W, default 7: opcode field width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port Opcode, input, OPCODE_W: instruction opcode, sampled only when ir_write=1.
REQ-006 SHALL have port imem_ready, input, 1: instruction memory has returned data.
REQ-007 SHALL have port dmem_ready, input, 1: data memory access complete.
REQ-008 SHALL have outputs imem_req, ir_write, pc_write, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch: each 1 bit, with the classic single-cycle meanings plus fetch, IR-load and PC-update strobes.
REQ-009 SHALL have output ALUOp, 2 bits: 00 load/store, 01 branch, 10 R/I-type.
REQ-010 SHALL have outputs illegal and timeout, 1 bit each: sticky error flags, plus output state_o, 3 bits: current state encoding.

Function
REQ-011 SHALL implement Moore FSM states FETCH, DECODE, EXEC, ADDR, MEM, WB, BRANCH, ERROR.
REQ-012 FETCH SHALL assert imem_req until imem_ready=1; that cycle SHALL assert ir_write and pc_write, latch Opcode, and go to DECODE.
REQ-013 DECODE SHALL last exactly 1 cycle, with next state by latched opcode:
  - 0110011 / 0010011 -> EXEC
  - 0000011 / 0100011 -> ADDR
  - 1100011 -> BRANCH
  - other -> ERROR, with illegal set.
REQ-014 EXEC SHALL drive ALUOp=10, with ALUSrc=1 only for 0010011, then go to WB.
REQ-015 ADDR SHALL drive ALUSrc=1, ALUOp=00 for 1 cycle, then go to MEM.
REQ-016 MEM SHALL hold MemRead (load) or MemWrite (store) until dmem_ready=1.
  - dmem_ready in the same cycle as the request SHALL complete the access in that cycle.
  - Load -> WB with MemtoReg=1; store -> FETCH.
REQ-017 MEM SHALL count wait cycles. If the count reaches MEM_TIMEOUT without dmem_ready, it SHALL deassert the request, set timeout and go to ERROR.
REQ-018 WB SHALL assert RegWrite for exactly 1 cycle, with MemtoReg retained from a load, then go to FETCH.
REQ-019 BRANCH SHALL assert Branch=1, ALUOp=01 for 1 cycle, then go to FETCH.
REQ-020 ERROR SHALL drive all strobes 0 and remain there until reset.
REQ-021 Opcode changes outside the ir_write cycle SHALL have no effect.
REQ-022 Every control output not listed for a state SHALL be 0 in that state.

Reset
REQ-023 reset=1 at an edge SHALL force FETCH, clear the opcode register, wait counter, illegal and timeout; every strobe and ALUOp SHALL be 0 in the cycle after reset.
REQ-024 Reset during MEM or FETCH SHALL drop MemRead/MemWrite/imem_req on the next edge, with no completion pulse.
REQ-025 imem_req SHALL re-assert in the first cycle after reset deasserts.

Configuration
REQ-026 With CTRL_JUMP_EN defined:
  - DECODE SHALL route 1101111 (jal) and 1100111 (jalr) to a JUMP state asserting pc_write and RegWrite for 1 cycle, then FETCH.
  - jalr SHALL additionally assert ALUSrc=1.
  - state_o SHALL widen to 4 bits.
REQ-027 Without CTRL_JUMP_EN, jal and jalr SHALL be illegal per REQ-013.

Structure
REQ-028 Package ctrl_pkg SHALL hold the state enum, opcode constants and ALUOp encodings.
REQ-029 Sub-module wait_timer SHALL provide the clear/enable/expire counter for REQ-017, with width $clog2(MEM_TIMEOUT+1).

Verification
REQ-030 The bench SHALL cover these scenarios:
  - add (0110011), imem_ready immediate: FETCH, DECODE, EXEC, WB; RegWrite pulse on cycle 4; back in FETCH on cycle 5.
  - lw, dmem_ready after 3 cycles: MemRead high 3 cycles, then WB with MemtoReg=1 and RegWrite=1.
  - sw, dmem_ready never: MemWrite high 15 cycles, then timeout=1, state ERROR, all strobes 0.
  - Opcode 1111111: illegal=1 after DECODE; reset then clears it and imem_req=1 next cycle.
  - beq: Branch=1 and ALUOp=01 for exactly 1 cycle.
  - jal, with and without CTRL_JUMP_EN: JUMP pulse vs illegal=1.
